// File: rtl/game_round_fsm.sv
// Game-flow controller for Whac-A-Mole: setup, countdown delay, play, pause,
// multi-round progression and game over. All outputs are registered so the
// mole generator, timer and display see glitch-free, edge-aligned signals.
//
// Handshake note: there are no valid/ready channels here. start, pause and
// restart are single-cycle strobes, already debounced upstream, and are
// sampled on every rising clk edge. time_over and score_zero are levels.
module game_round_fsm #(
  parameter int ROUNDS       = 3,
  parameter int DELAY_CYCLES = 50,
  parameter int RND_W        = 2,
  parameter int DLY_W        = 6
) (
  input  logic             clk,
  input  logic             rst_n,        // asynchronous, active-high
  input  logic             start,
  input  logic             pause,
  input  logic             restart,
  input  logic             time_over,
  input  logic             score_zero,
  output logic [2:0]       state,
  output logic [RND_W-1:0] round,
  output logic [DLY_W-1:0] delay_cnt,
  output logic             play_en,
  output logic             round_start,
  output logic             game_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_PLAY    = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;
  localparam logic [2:0] S_RND_END = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             play_en_q, play_en_d;
  logic             rstart_q, rstart_d;
  logic             done_q, done_d;

  // Next-state, round and delay counter; restart overrides every state rule.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    dly_d   = dly_q;
    if (restart && (state_q != S_IDLE)) begin
      state_d = S_SETUP;
      round_d = '0;
      dly_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_SETUP;
        S_SETUP: begin
          if (start) begin
            state_d = S_DELAY;
            dly_d   = DLY_LOAD;
            round_d = '0;
          end
        end
        S_DELAY: begin
          // The counter shows remaining cycles minus one, so the cycle that
          // reads zero is the last DELAY cycle.
          if (dly_q == '0) state_d = S_PLAY;
          else             dly_d   = dly_q - 1'b1;
        end
        S_PLAY: begin
          if (score_zero)     state_d = S_OVER;
          else if (time_over) state_d = S_RND_END;
          else if (pause)     state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (pause) state_d = S_PLAY;
        end
        S_RND_END: begin
          if (round_q == LAST_RND) begin
            state_d = S_OVER;
          end else begin
            state_d = S_DELAY;
            round_d = round_q + 1'b1;
            dly_d   = DLY_LOAD;
          end
        end
        S_OVER: state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered status outputs derived from the transition being taken.
  always_comb begin
    play_en_d = (state_d == S_PLAY);
    rstart_d  = (state_q == S_DELAY) && (state_d == S_PLAY);
    done_d    = (state_q != S_OVER) && (state_d == S_OVER);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      dly_q     <= '0;
      play_en_q <= 1'b0;
      rstart_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      dly_q     <= dly_d;
      play_en_q <= play_en_d;
      rstart_q  <= rstart_d;
      done_q    <= done_d;
    end
  end

  assign state       = state_q;
  assign round       = round_q;
  assign delay_cnt   = dly_q;
  assign play_en     = play_en_q;
  assign round_start = rstart_q;
  assign game_done   = done_q;

endmodule

// File: tb/tb_game_round_fsm.sv
// Bench for game_round_fsm with ROUNDS=3, DELAY_CYCLES=4: a directed vector
// table, hand-written async-reset sequences, then random strobes compared
// against a phase-level reference model.
module tb_game_round_fsm;

  localparam int ROUNDS = 3;
  localparam int DC     = 4;
  localparam int RND_W  = 2;
  localparam int DLY_W  = 3;
  localparam int EW     = 3 + RND_W + DLY_W + 3;

  localparam int P_IDLE = 0, P_SETUP = 1, P_DELAY = 2, P_PLAY = 3,
                 P_PAUSE = 4, P_RND_END = 5, P_OVER = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0, pause = 1'b0, restart = 1'b0;
  logic             time_over = 1'b0, score_zero = 1'b0;
  logic [2:0]       state;
  logic [RND_W-1:0] round;
  logic [DLY_W-1:0] delay_cnt;
  logic             play_en, round_start, game_done;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  game_round_fsm #(.ROUNDS(ROUNDS), .DELAY_CYCLES(DC), .RND_W(RND_W), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .restart(restart),
    .time_over(time_over), .score_zero(score_zero), .state(state), .round(round),
    .delay_cnt(delay_cnt), .play_en(play_en), .round_start(round_start),
    .game_done(game_done)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: game phase, round number and DELAY cycles still to run.
  int m_phase, m_round, m_left, m_prev;

  function automatic void model_reset();
    m_phase = P_IDLE; m_round = 0; m_left = 0; m_prev = P_IDLE;
  endfunction

  function automatic void model_step(input bit st, input bit pa, input bit rs,
                                     input bit to, input bit sz);
    m_prev = m_phase;
    if (rs && m_phase != P_IDLE) begin
      m_phase = P_SETUP; m_round = 0; m_left = 0;
    end else if (m_phase == P_IDLE) begin
      m_phase = P_SETUP;
    end else if (m_phase == P_SETUP) begin
      if (st) begin m_phase = P_DELAY; m_left = DC; m_round = 0; end
    end else if (m_phase == P_DELAY) begin
      if (m_left <= 1) m_phase = P_PLAY;
      else m_left = m_left - 1;
    end else if (m_phase == P_PLAY) begin
      if (sz) m_phase = P_OVER;
      else if (to) m_phase = P_RND_END;
      else if (pa) m_phase = P_PAUSE;
    end else if (m_phase == P_PAUSE) begin
      if (pa) m_phase = P_PLAY;
    end else if (m_phase == P_RND_END) begin
      if (m_round + 1 >= ROUNDS) m_phase = P_OVER;
      else begin m_round = m_round + 1; m_left = DC; m_phase = P_DELAY; end
    end
  endfunction

  function automatic logic [EW-1:0] model_out();
    int dly;
    dly = (m_left == 0) ? 0 : m_left - 1;
    return {3'(m_phase), RND_W'(m_round), DLY_W'(dly),
            1'(m_phase == P_PLAY),
            1'(m_prev == P_DELAY && m_phase == P_PLAY),
            1'(m_prev != P_OVER && m_phase == P_OVER)};
  endfunction

  // Scoreboard: pop one expected record and compare field by field.
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag);
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    chk({tag, ".state"},       int'(state),       int'(e[EW-1 -: 3]));
    chk({tag, ".round"},       int'(round),       int'(e[EW-4 -: RND_W]));
    chk({tag, ".delay_cnt"},   int'(delay_cnt),   int'(e[DLY_W+2 -: DLY_W]));
    chk({tag, ".play_en"},     int'(play_en),     int'(e[2]));
    chk({tag, ".round_start"}, int'(round_start), int'(e[1]));
    chk({tag, ".game_done"},   int'(game_done),   int'(e[0]));
  endtask

  // Driver: apply one cycle of strobes, then check #1 after the edge.
  task automatic drive(input bit st, input bit pa, input bit rs, input bit to,
                       input bit sz, input string tag);
    start = st; pause = pa; restart = rs; time_over = to; score_zero = sz;
    @(posedge clk);
    #1;
    model_step(st, pa, rs, to, sz);
    exp_q.push_back(model_out());
    compare(tag);
    start = 0; pause = 0; restart = 0; time_over = 0; score_zero = 0;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_out());
    compare(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  typedef struct {
    bit st, pa, rs, to, sz;
    int e_state, e_round, e_dly;
    bit e_pe, e_rs, e_gd;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit st, input bit pa, input bit rs, input bit to,
                              input bit sz, input int es, input int er, input int ed,
                              input bit pe, input bit rsp, input bit gd);
    vec_t v;
    v.st = st; v.pa = pa; v.rs = rs; v.to = to; v.sz = sz;
    v.e_state = es; v.e_round = er; v.e_dly = ed;
    v.e_pe = pe; v.e_rs = rsp; v.e_gd = gd;
    vt.push_back(v);
  endfunction

  initial begin
    // Directed table, written from the game rules (ROUNDS=3, DELAY=4).
    //  st pa rs to sz  state rnd dly pe rs gd
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // IDLE -> SETUP
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);   // SETUP ignores levels
    add(1, 0, 0, 0, 0, 2, 0, 3, 0, 0, 0);   // start -> DELAY 3
    add(0, 1, 0, 1, 0, 2, 0, 2, 0, 0, 0);   // DELAY ignores inputs
    add(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 0);   // PLAY, round_start
    add(0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0);   // pause
    add(0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0);   // levels ignored in PAUSE
    add(0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0);   // resume, no round_start
    add(0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0);   // time_over -> RND_END
    add(0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 2, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 2, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 2, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 5, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 6, 2, 0, 0, 0, 1);   // last round -> OVER
    add(1, 1, 0, 0, 0, 6, 2, 0, 0, 0, 0);   // OVER holds, single pulse
    add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);   // restart from OVER
    add(1, 0, 0, 0, 0, 2, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);   // restart at delay_cnt=2 wins
    add(1, 0, 0, 0, 0, 2, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 1);   // score_zero beats time_over
    add(0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    // Reset and idle-state check
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    exp_q.push_back(model_out());
    compare("reset_hold");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model_out());
    compare("idle_after_release");

    for (int i = 0; i < vt.size(); i++) begin
      start = vt[i].st; pause = vt[i].pa; restart = vt[i].rs;
      time_over = vt[i].to; score_zero = vt[i].sz;
      @(posedge clk);
      #1;
      model_step(vt[i].st, vt[i].pa, vt[i].rs, vt[i].to, vt[i].sz);
      exp_q.push_back({3'(vt[i].e_state), RND_W'(vt[i].e_round), DLY_W'(vt[i].e_dly),
                       vt[i].e_pe, vt[i].e_rs, vt[i].e_gd});
      compare($sformatf("vec%0d", i));
      start = 0; pause = 0; restart = 0; time_over = 0; score_zero = 0;
    end

    // Hand sequence: async reset while in PLAY clears outputs immediately.
    drive(1, 0, 0, 0, 0, "seq_start");
    repeat (DC) drive(0, 0, 0, 0, 0, "seq_delay");
    do_reset("async_reset_play");
    drive(0, 0, 0, 0, 0, "seq_idle_to_setup");

    // Hand sequence: restart in IDLE is ignored (IDLE -> SETUP anyway).
    do_reset("async_reset_setup");
    drive(0, 0, 1, 0, 0, "restart_in_idle");

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rand_reset");
      end else begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 19) == 0, "rand");
      end
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
